// File: rtl/dino_pkg.sv
// Shared definitions for the dino game: player state encoding and game_tick phase indices.
package dino_pkg;

    localparam int unsigned PSTATE_W = 3;
    localparam int unsigned TICK_W   = 2;

    localparam logic [PSTATE_W-1:0] PS_IDLE = 3'd0;
    localparam logic [PSTATE_W-1:0] PS_RUN  = 3'd1;
    localparam logic [PSTATE_W-1:0] PS_JUMP = 3'd2;
    localparam logic [PSTATE_W-1:0] PS_DUCK = 3'd3;
    localparam logic [PSTATE_W-1:0] PS_DEAD = 3'd4;

    localparam logic [0:0] TICK_VEL = 1'b0;
    localparam logic [0:0] TICK_POS = 1'b1;

    typedef enum logic [PSTATE_W-1:0] {
        ST_IDLE = PS_IDLE,
        ST_RUN  = PS_RUN,
        ST_JUMP = PS_JUMP,
        ST_DUCK = PS_DUCK,
        ST_DEAD = PS_DEAD
    } player_state_e;

endpackage

// File: rtl/button_debounce.sv
// Raw button -> 2-FF synchronizer -> debounced level plus one-cycle rise strobe.
// Counter only built when PLAYER_CTRL_DEBOUNCE_EN is defined; otherwise level follows the synchronizer.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_i,
    output logic level_o,
    output logic level_nxt_c,
    output logic rise_c
);

    if (DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("button_debounce: DEBOUNCE_CYCLES must be at least 1");
    end

    logic sync1_q, sync2_q;
    logic level_q, level_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
        end
    end

`ifdef PLAYER_CTRL_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive disagreeing cycles; flip once DEBOUNCE_CYCLES have been seen.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        level_d = sync2_q;
    end
`endif

    assign level_o     = level_q;
    assign level_nxt_c = level_d;
    assign rise_c      = level_d & ~level_q;

endmodule

// File: rtl/player_controller.sv
// Dino player front-end: button conditioning, two-phase game_tick sequencing and player state FSM.
// Optional debounce counters enabled by defining PLAYER_CTRL_DEBOUNCE_EN.
module player_controller
    import dino_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_tick,
    input  logic                game_over,
    input  logic                btn_jump_raw,
    input  logic                btn_down_raw,
    input  logic                jump_done,
    output logic [TICK_W-1:0]   game_tick,
    output logic                jump_pulse,
    output logic                button_down,
    output logic [PSTATE_W-1:0] player_state,
    output logic                start,
    output logic                restart
);

    logic jump_level, jump_level_nxt, jump_press;
    logic down_level, down_level_nxt, down_rise;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_jump_db (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw_i   (btn_jump_raw),
        .level_o     (jump_level),
        .level_nxt_c (jump_level_nxt),
        .rise_c      (jump_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down_db (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw_i   (btn_down_raw),
        .level_o     (down_level),
        .level_nxt_c (down_level_nxt),
        .rise_c      (down_rise)
    );

    logic unused_levels;
    assign unused_levels = ^{jump_level, jump_level_nxt, down_rise};

    player_state_e     state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              jump_req_q, jump_req_d;
    logic              jump_pulse_q, jump_pulse_d;
    logic              start_q, start_d;
    logic              restart_q, restart_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tick_q       <= '0;
            jump_req_q   <= 1'b0;
            jump_pulse_q <= 1'b0;
            start_q      <= 1'b0;
            restart_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            jump_req_q   <= jump_req_d;
            jump_pulse_q <= jump_pulse_d;
            start_q      <= start_d;
            restart_q    <= restart_d;
        end
    end

    always_comb begin
        tick_d     = '0;
        jump_req_d = jump_req_q;
        state_d    = state_q;
        start_d    = 1'b0;
        restart_d  = 1'b0;

        // A new frame_tick is only accepted when no sequence is in flight.
        if (tick_q[TICK_VEL]) begin
            tick_d[TICK_POS] = 1'b1;
        end else if (!tick_q[TICK_POS] && frame_tick) begin
            tick_d[TICK_VEL] = 1'b1;
        end

        if (tick_q[TICK_VEL]) begin
            jump_req_d = 1'b0;
        end
        if (jump_press && state_q == ST_RUN) begin
            jump_req_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (jump_press) begin
                    state_d = ST_RUN;
                    start_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (jump_pulse_q) begin
                    state_d = ST_JUMP;
                end else if (down_level) begin
                    state_d = ST_DUCK;
                end
            end
            ST_JUMP: begin
                if (tick_q[TICK_POS] && jump_done) begin
                    state_d = down_level ? ST_DUCK : ST_RUN;
                end
            end
            ST_DUCK: begin
                if (!down_level) begin
                    state_d = ST_RUN;
                end
            end
            ST_DEAD: begin
                if (jump_press) begin
                    restart_d = 1'b1;
                end else if (!game_over) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (game_over) begin
            state_d = ST_DEAD;
            start_d = 1'b0;
        end

        // Evaluated on next-cycle values so the registered pulse lines up with game_tick[0].
        jump_pulse_d = tick_d[TICK_VEL] & jump_req_d & (state_d == ST_RUN) & ~down_level_nxt;
    end

    assign game_tick    = tick_q;
    assign jump_pulse   = jump_pulse_q;
    assign button_down  = down_level;
    assign player_state = state_q;
    assign start        = start_q;
    assign restart      = restart_q;

endmodule
